// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the word-granular memory copy initiator.
package mem_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FINISH
    } copy_state_e;

    localparam logic [3:0] BeWord    = 4'hF;
    localparam int         WordBytes = 4;

    // Byte address of word idx relative to base; wraps modulo 2^32 by construction.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << $clog2(WordBytes));
    endfunction

endpackage

// File: rtl/mem_copy_initiator.sv
// Memory copy engine: reads len words from src and writes them to dst over a
// single-outstanding req/gnt/rvalid data bus, reporting done/error when finished.
module mem_copy_initiator
    import mem_copy_pkg::*;
#(
    parameter int LenWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [31:0]         src_addr_i,
    input  logic [31:0]         dst_addr_i,
    input  logic [LenWidth-1:0] len_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [LenWidth-1:0] words_done_o,
    output logic                data_req_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    output logic                data_we_o,
    output logic [3:0]          data_be_o,
    output logic [31:0]         data_addr_o,
    output logic [31:0]         data_wdata_o,
    input  logic [31:0]         data_rdata_i,
    input  logic                data_err_i
);

    copy_state_e state_q, state_d;

    logic [31:0]         src_q, dst_q, buf_q;
    logic [LenWidth-1:0] len_q;
    logic                abort_q;

    logic [31:0]         src_d, dst_d, buf_d;
    logic [LenWidth-1:0] len_d, cnt_d;
    logic                abort_d, err_d, busy_d, done_d;
    logic                req_d, we_d;
    logic [3:0]          be_d;
    logic [31:0]         addr_d, wdata_d;

    logic accept, misaligned, active, waiting;
    logic rsp_ok, rsp_err, rd_done, word_cmp, last_word;

    assign accept     = (state_q == IDLE) && start_i;
    assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
    assign active     = (state_q == RD_REQ) || (state_q == RD_WAIT) ||
                        (state_q == WR_REQ) || (state_q == WR_WAIT);

    // A response is only meaningful once the current request has been granted.
    assign waiting    = (((state_q == RD_REQ) || (state_q == WR_REQ)) && data_gnt_i) ||
                        (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign rsp_ok     = waiting && data_rvalid_i && !data_err_i;
    assign rsp_err    = waiting && data_rvalid_i && data_err_i;
    assign rd_done    = rsp_ok && ((state_q == RD_REQ) || (state_q == RD_WAIT));
    assign word_cmp   = rsp_ok && ((state_q == WR_REQ) || (state_q == WR_WAIT));
    assign last_word  = ((words_done_o + LenWidth'(1)) == len_q) || abort_q || abort_i;

    // ---- state register ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ((len_i == '0) || misaligned) ? FINISH : RD_REQ;
                end
            end
            RD_REQ: begin
                if (rsp_err)         state_d = FINISH;
                else if (rd_done)    state_d = WR_REQ;
                else if (data_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (rsp_err)      state_d = FINISH;
                else if (rd_done) state_d = WR_REQ;
            end
            WR_REQ: begin
                if (rsp_err)         state_d = FINISH;
                else if (word_cmp)   state_d = last_word ? FINISH : RD_REQ;
                else if (data_gnt_i) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (rsp_err)       state_d = FINISH;
                else if (word_cmp) state_d = last_word ? FINISH : RD_REQ;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- output logic: next values of the registered Moore outputs ----
    always_comb begin
        src_d   = accept ? src_addr_i : src_q;
        dst_d   = accept ? dst_addr_i : dst_q;
        len_d   = accept ? len_i : len_q;
        buf_d   = rd_done ? data_rdata_i : buf_q;
        cnt_d   = accept ? '0 : (word_cmp ? words_done_o + LenWidth'(1) : words_done_o);
        err_d   = accept ? misaligned : (rsp_err ? 1'b1 : err_o);
        abort_d = accept ? 1'b0 : ((active && abort_i) ? 1'b1 : abort_q);

        req_d   = 1'b0;
        we_d    = data_we_o;
        be_d    = data_be_o;
        addr_d  = data_addr_o;
        wdata_d = data_wdata_o;
        unique case (state_d)
            RD_REQ: begin
                req_d  = 1'b1;
                we_d   = 1'b0;
                be_d   = BeWord;
                addr_d = word_addr(src_d, 32'(cnt_d));
            end
            WR_REQ: begin
                req_d   = 1'b1;
                we_d    = 1'b1;
                be_d    = BeWord;
                addr_d  = word_addr(dst_d, 32'(cnt_d));
                wdata_d = buf_d;
            end
            default: ;
        endcase

        busy_d = (state_d == RD_REQ) || (state_d == RD_WAIT) ||
                 (state_d == WR_REQ) || (state_d == WR_WAIT);
        done_d = (state_d == FINISH);
    end

    // ---- output and control registers ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            words_done_o <= '0;
            abort_q      <= 1'b0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= '0;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
        end else begin
            busy_o       <= busy_d;
            done_o       <= done_d;
            err_o        <= err_d;
            words_done_o <= cnt_d;
            abort_q      <= abort_d;
            data_req_o   <= req_d;
            data_we_o    <= we_d;
            data_be_o    <= be_d;
            data_addr_o  <= addr_d;
            data_wdata_o <= wdata_d;
        end
    end

    // Copy parameters and the word buffer need no reset; they are loaded before use.
    always_ff @(posedge clk_i) begin
        src_q <= src_d;
        dst_q <= dst_d;
        len_q <= len_d;
        buf_q <= buf_d;
    end

`ifndef SYNTHESIS
    a_req_stable: assert property (@(posedge clk_i)
        (data_req_o && !data_gnt_i && !rst_i) |=>
        (rst_i || (data_req_o && $stable(data_addr_o) && $stable(data_we_o) &&
                   $stable(data_be_o) && $stable(data_wdata_o))))
        else $error("request changed before grant");

    a_done_pulse: assert property (@(posedge clk_i) done_o |=> !done_o)
        else $error("done_o longer than one cycle");

    a_busy_state: assert property (@(posedge clk_i) rst_i || (busy_o == active))
        else $error("busy_o does not track copy state");

    a_rvalid_expected: assert property (@(posedge clk_i) (data_rvalid_i && !rst_i) |-> waiting)
        else $error("rvalid with no outstanding request");
`endif

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Directed bench for mem_copy_initiator: a bus responder with selectable timing plus
// a transaction-level model of the expected reads/writes and copy outcome.
module tb_mem_copy_initiator;

    logic        clk = 1'b0;
    logic        rst_i, start_i, abort_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, err_o;
    logic [15:0] words_done_o;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o, data_err_i;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

    mem_copy_initiator #(.LenWidth(16)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .src_addr_i    (src_addr_i),
        .dst_addr_i    (dst_addr_i),
        .len_i         (len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .words_done_o  (words_done_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_addr_o   (data_addr_o),
        .data_wdata_o  (data_wdata_o),
        .data_rdata_i  (data_rdata_i),
        .data_err_i    (data_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t wlog[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Responder: 0 = rvalid one cycle after gnt, 1 = gnt+rvalid together,
    // 2 = random 0-5 cycle gnt stall, 3 = reads as mode 0 but writes never granted.
    int          mode = 0;
    int          err_word = -1;
    int          rd_idx = 0;
    int          stall_left = 0;
    bit          hold = 0;
    bit          rsp_pend = 0;
    logic [31:0] pend_data;
    logic        pend_err;
    logic [31:0] sv_addr, sv_wdata;
    logic        sv_we;
    logic [3:0]  sv_be;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic responder_step();
        txn_t        t, e;
        logic [31:0] rd;
        logic        re;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        data_rdata_i  = '0;
        if (rsp_pend) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = pend_data;
            data_err_i    = pend_err;
            rsp_pend      = 0;
        end
        if (data_req_o) begin
            if (hold) begin
                check("stable_addr",  data_addr_o,  sv_addr);
                check("stable_we",    32'(data_we_o), 32'(sv_we));
                check("stable_be",    32'(data_be_o), 32'(sv_be));
                check("stable_wdata", data_wdata_o, sv_wdata);
            end else begin
                sv_addr    = data_addr_o;
                sv_we      = data_we_o;
                sv_be      = data_be_o;
                sv_wdata   = data_wdata_o;
                stall_left = (mode == 2) ? int'($urandom_range(0, 5)) : 0;
            end
            if ((mode == 3 && data_we_o) || stall_left > 0) begin
                if (stall_left > 0) stall_left--;
                hold = 1;
            end else begin
                hold       = 0;
                data_gnt_i = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_txn", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_we",   32'(data_we_o), 32'(e.we));
                    check("txn_addr", data_addr_o, e.addr);
                    check("txn_be",   32'(data_be_o), 32'hF);
                    if (e.we) check("txn_wdata", data_wdata_o, e.data);
                end
                rd = '0;
                re = 1'b0;
                if (!data_we_o) begin
                    rd = pat(data_addr_o);
                    re = (rd_idx == err_word);
                    rd_idx++;
                end else begin
                    t.we = 1'b1; t.addr = data_addr_o; t.data = data_wdata_o;
                    wlog.push_back(t);
                end
                if (mode == 1) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = rd;
                    data_err_i    = re;
                end else begin
                    rsp_pend  = 1;
                    pend_data = rd;
                    pend_err  = re;
                end
            end
        end else begin
            hold = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        responder_step();
    endtask

    // Model: expected bus traffic and outcome derived from the copy request alone.
    task automatic run_copy(input string nm, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input int m, input int errw,
                            input int abw, input int exp_lat);
        int   words, nrd, c0, lat;
        bit   aligned, got;
        logic xerr;
        txn_t t;
        aligned = (s[1:0] == 2'b00) && (d[1:0] == 2'b00);
        xerr    = !aligned;
        words   = 0;
        nrd     = 0;
        if (aligned && l != 0) begin
            if (errw >= 0 && errw < int'(l)) begin
                words = errw; nrd = errw + 1; xerr = 1'b1;
            end else if (abw >= 0 && abw < int'(l)) begin
                words = abw + 1; nrd = words;
            end else begin
                words = int'(l); nrd = words;
            end
        end
        exp_q.delete();
        wlog.delete();
        for (int i = 0; i < nrd; i++) begin
            t.we = 1'b0; t.addr = s + 32'(4 * i); t.data = '0;
            exp_q.push_back(t);
            if (i < words) begin
                t.we = 1'b1; t.addr = d + 32'(4 * i); t.data = pat(s + 32'(4 * i));
                exp_q.push_back(t);
            end
        end
        mode = m; err_word = errw; rd_idx = 0;
        cycle();
        start_i = 1'b1; src_addr_i = s; dst_addr_i = d; len_i = l;
        c0  = cyc;
        got = 0;
        lat = 0;
        for (int k = 0; k < 500 && !got; k++) begin
            cycle();
            start_i = 1'b0;
            abort_i = (abw >= 0) && (cyc == c0 + 4 * abw + 2);
            @(negedge clk);
            if (done_o) begin
                got = 1;
                lat = cyc - c0 + 1;
            end
        end
        abort_i = 1'b0;
        if (!got) begin
            check({nm, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            if (exp_lat > 0) check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
            check({nm, "_err"},   32'(err_o), 32'(xerr));
            check({nm, "_words"}, 32'(words_done_o), 32'(words));
            check({nm, "_busy_in_finish"}, 32'(busy_o), 32'd0);
            cycle();
            @(negedge clk);
            check({nm, "_done_single"}, 32'(done_o), 32'd0);
            check({nm, "_txn_left"},    32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        src_addr_i = '0; dst_addr_i = '0; len_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
        repeat (3) cycle();
        @(negedge clk);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_err",   32'(err_o),  32'd0);
        check("rst_req",   32'(data_req_o), 32'd0);
        check("rst_we",    32'(data_we_o),  32'd0);
        check("rst_be",    32'(data_be_o),  32'd0);
        check("rst_addr",  data_addr_o,  32'd0);
        check("rst_wdata", data_wdata_o, 32'd0);
        check("rst_words", 32'(words_done_o), 32'd0);
        rst_i = 1'b0;

        run_copy("basic", 32'h100, 32'h200, 16'd3, 0, -1, -1, 14);
        check("basic_wlog_n", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            check("basic_w0_addr", wlog[0].addr, 32'h0000_0200);
            check("basic_w0_data", wlog[0].data, 32'h0100_FEFF);
            check("basic_w2_addr", wlog[2].addr, 32'h0000_0208);
            check("basic_w2_data", wlog[2].data, 32'h0108_FEF7);
        end
        check("basic_words_lit", 32'(words_done_o), 32'd3);

        run_copy("fast", 32'h400, 32'h500, 16'd2, 1, -1, -1, 6);
        run_copy("stall", 32'h1000, 32'h2000, 16'd8, 2, -1, -1, -1);
        check("stall_wlog_n", 32'(wlog.size()), 32'd8);

        run_copy("rderr", 32'h300, 32'h600, 16'd4, 0, 2, -1, 12);
        check("rderr_err_lit",   32'(err_o), 32'd1);
        check("rderr_words_lit", 32'(words_done_o), 32'd2);
        check("rderr_wlog_n",    32'(wlog.size()), 32'd2);

        run_copy("len0", 32'h100, 32'h200, 16'd0, 0, -1, -1, 2);
        check("len0_err_lit", 32'(err_o), 32'd0);
        run_copy("misal", 32'h102, 32'h200, 16'd3, 0, -1, -1, 2);
        check("misal_err_lit", 32'(err_o), 32'd1);

        run_copy("abort", 32'h700, 32'h800, 16'd5, 0, -1, 1, 10);
        check("abort_words_lit", 32'(words_done_o), 32'd2);
        check("abort_err_lit",   32'(err_o), 32'd0);

        run_copy("wrap", 32'hFFFF_FFF8, 32'h10, 16'd3, 1, -1, -1, 8);
        if (wlog.size() == 3) begin
            check("wrap_w2_addr", wlog[2].addr, 32'h0000_0018);
            check("wrap_w2_data", wlog[2].data, 32'h0000_FFFF);
        end else begin
            check("wrap_wlog_n", 32'(wlog.size()), 32'd3);
        end

        // Reset while a write request waits for its grant.
        mode = 3; err_word = -1; rd_idx = 0;
        exp_q.delete();
        begin
            txn_t t;
            t.we = 1'b0; t.addr = 32'h900; t.data = '0;
            exp_q.push_back(t);
        end
        cycle();
        start_i = 1'b1; src_addr_i = 32'h900; dst_addr_i = 32'hA00; len_i = 16'd4;
        cycle();
        start_i = 1'b0;
        cycle();
        cycle();
        @(negedge clk);
        check("rstmid_req_pre",   32'(data_req_o), 32'd1);
        check("rstmid_we_pre",    32'(data_we_o),  32'd1);
        check("rstmid_addr_pre",  data_addr_o,  32'hA00);
        check("rstmid_wdata_pre", data_wdata_o, pat(32'h900));
        rst_i = 1'b1;
        cycle();
        @(negedge clk);
        check("rstmid_req",   32'(data_req_o), 32'd0);
        check("rstmid_busy",  32'(busy_o), 32'd0);
        check("rstmid_done",  32'(done_o), 32'd0);
        check("rstmid_err",   32'(err_o),  32'd0);
        check("rstmid_we",    32'(data_we_o), 32'd0);
        check("rstmid_be",    32'(data_be_o), 32'd0);
        check("rstmid_addr",  data_addr_o,  32'd0);
        check("rstmid_wdata", data_wdata_o, 32'd0);
        check("rstmid_words", 32'(words_done_o), 32'd0);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            @(negedge clk);
            check("rstmid_no_done", 32'(done_o), 32'd0);
            check("rstmid_no_req",  32'(data_req_o), 32'd0);
        end
        check("rstmid_txn_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
